instr_fetch_unit: RTL and testbench

- Fetch stage of the MicroUAZ8 8-bit core, directly upstream of Num_Inm and the decoder.
- Holds the program counter and issues read requests to program memory over a req/ack handshake.
- Latches the returned byte into an instruction register that drives i_Instruction of Num_Inm/decoder.
- Supports decoder stall and taken jumps/branches (flush of any in-flight fetch).

---
 rtl/uaz8_pkg.sv | 24 ++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uaz8_pkg.sv
// Shared definitions for the MicroUAZ8 core: bus widths, reset vector and
// the fetch-stage state encoding.
package uaz8_pkg;

    // Program memory address width (also the program counter width).
    localparam int UAZ8_ADDR_W = 8;

    // Instruction byte width.
    localparam int UAZ8_DATA_W = 8;

    // Program counter value after reset.
    localparam logic [UAZ8_ADDR_W-1:0] UAZ8_RESET_VEC = 8'h00;

    // Fetch stage states:
    //   IDLE  - one cycle after reset before the first request goes out
    //   FETCH - request outstanding, waiting for the memory acknowledge
    //   ISSUE - instruction register holds an unconsumed instruction
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } fetch_state_e;

endpackage : uaz8_pkg

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the MicroUAZ8 core. Owns the program counter, runs the
// req/ack handshake towards program memory and presents one instruction
// at a time to Num_Inm and the decoder. A jump redirects the PC and drops
// whatever is in flight or held. Every output comes straight from a flop.
module instr_fetch_unit
    import uaz8_pkg::*;
#(
    parameter int                ADDR_W    = UAZ8_ADDR_W,
    parameter int                DATA_W    = UAZ8_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = UAZ8_RESET_VEC
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    output logic [ADDR_W-1:0] o_Pmem_Addr,
    output logic              o_Pmem_Req,
    input  logic              i_Pmem_Ack,
    input  logic [DATA_W-1:0] i_Pmem_Data,
    input  logic              i_Stall,
    input  logic              i_Jump,
    input  logic [ADDR_W-1:0] i_Jump_Addr,
    output logic [DATA_W-1:0] o_Instruction,
    output logic              o_Instr_Valid,
    output logic [ADDR_W-1:0] o_Instr_Addr
);

    // Next sequential PC; the natural ADDR_W-bit overflow gives the
    // required wrap from all-ones back to zero.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              req_q,   req_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;

    // Data only counts while our own request is up; a stray ack is ignored.
    logic              mem_hit;
    assign mem_hit = req_q && i_Pmem_Ack;

    // Next-state and next-output logic; a jump overrides stall and ack.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        instr_d = instr_q;
        valid_d = valid_q;
        iaddr_d = iaddr_q;

        if (i_Jump) begin
            // Redirect: flush any held instruction, discard any data
            // returning this cycle and (re)issue the request at the target.
            pc_d    = i_Jump_Addr;
            addr_d  = i_Jump_Addr;
            req_d   = 1'b1;
            valid_d = 1'b0;
            state_d = FETCH;
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
                FETCH: begin
                    // Request and address stay put until memory answers.
                    if (mem_hit) begin
                        instr_d = i_Pmem_Data;
                        iaddr_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc(pc_q);
                        req_d   = 1'b0;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    // Decoder takes the instruction when it is not stalling.
                    if (!i_Stall) begin
                        valid_d = 1'b0;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            addr_q  <= RESET_VEC;
            req_q   <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
            iaddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            iaddr_q <= iaddr_d;
        end
    end

    assign o_Pmem_Addr   = addr_q;
    assign o_Pmem_Req    = req_q;
    assign o_Instruction = instr_q;
    assign o_Instr_Valid = valid_q;
    assign o_Instr_Addr  = iaddr_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random
// ack/stall/jump traffic, all compared cycle by cycle against a
// transaction-level reference of the fetch stage.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ack;
    logic [7:0] data;
    logic       stall;
    logic       jump;
    logic [7:0] jaddr;

    logic [7:0] o_Pmem_Addr;
    logic       o_Pmem_Req;
    logic [7:0] o_Instruction;
    logic       o_Instr_Valid;
    logic [7:0] o_Instr_Addr;

    instr_fetch_unit dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .o_Pmem_Addr   (o_Pmem_Addr),
        .o_Pmem_Req    (o_Pmem_Req),
        .i_Pmem_Ack    (ack),
        .i_Pmem_Data   (data),
        .i_Stall       (stall),
        .i_Jump        (jump),
        .i_Jump_Addr   (jaddr),
        .o_Instruction (o_Instruction),
        .o_Instr_Valid (o_Instr_Valid),
        .o_Instr_Addr  (o_Instr_Addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: "started" = first request issued since reset,
    // "req_open" = request outstanding, "held" = instruction waiting.
    logic       m_started;
    logic       m_req_open;
    logic       m_held;
    logic [7:0] m_next_pc;
    logic [7:0] m_req_addr;
    logic [7:0] m_instr;
    logic [7:0] m_iaddr;

    function automatic logic [7:0] mem_byte(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_req_open = 1'b0;
        m_held     = 1'b0;
        m_next_pc  = 8'h00;
        m_req_addr = 8'h00;
        m_instr    = 8'h00;
        m_iaddr    = 8'h00;
    endtask

    // One clock edge worth of fetch-stage rules.
    task automatic model_edge(input logic a, input logic s, input logic j, input logic [7:0] ja);
        if (j) begin
            m_next_pc  = ja;
            m_req_addr = ja;
            m_req_open = 1'b1;
            m_held     = 1'b0;
            m_started  = 1'b1;
        end else if (!m_started) begin
            m_started  = 1'b1;
            m_req_open = 1'b1;
            m_req_addr = m_next_pc;
        end else if (m_req_open) begin
            if (a) begin
                m_instr    = mem_byte(m_req_addr);
                m_iaddr    = m_req_addr;
                m_next_pc  = m_req_addr + 8'h01;
                m_held     = 1'b1;
                m_req_open = 1'b0;
            end
        end else if (m_held && !s) begin
            m_held     = 1'b0;
            m_req_open = 1'b1;
            m_req_addr = m_next_pc;
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".req"},   32'(o_Pmem_Req),    32'(m_req_open));
        chk({where, ".addr"},  32'(o_Pmem_Addr),   32'(m_req_addr));
        chk({where, ".valid"}, 32'(o_Instr_Valid), 32'(m_held));
        chk({where, ".instr"}, 32'(o_Instruction), 32'(m_instr));
        chk({where, ".iaddr"}, 32'(o_Instr_Addr),  32'(m_iaddr));
    endtask

    // Drive one cycle of inputs, clock it, then compare at the falling edge.
    task automatic step(input logic a, input logic s, input logic j, input logic [7:0] ja,
                        input string where);
        ack   = a;
        stall = s;
        jump  = j;
        jaddr = ja;
        data  = a ? mem_byte(o_Pmem_Addr) : 8'($urandom);
        @(posedge clk);
        if (rst_n) model_edge(a, s, j, ja);
        @(negedge clk);
        check_all(where);
        ack  = 1'b0;
        jump = 1'b0;
    endtask

    task automatic do_reset();
        ack   = 1'b0;
        stall = 1'b0;
        jump  = 1'b0;
        jaddr = 8'h00;
        data  = 8'h00;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;
        #1;
        check_all("rst_rel");
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);

        // Zero-wait memory, no stall.
        do_reset();
        for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b0, 8'h00, "zw");
        chk("zw.iaddr_after6", 32'(o_Instr_Addr), 32'h05);
        chk("zw.instr_after6", 32'(o_Instruction), 32'h15);

        // Ack delayed by three cycles, then stall for five.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, "late0");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, "late");
            chk("late.req_held", 32'(o_Pmem_Req), 32'h1);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, "late_ack");
        chk("late.instr", 32'(o_Instruction), 32'h10);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00, "stall");
            chk("stall.valid", 32'(o_Instr_Valid), 32'h1);
            chk("stall.noreq", 32'(o_Pmem_Req), 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, "unstall");
        chk("unstall.req", 32'(o_Pmem_Req), 32'h1);
        chk("unstall.addr", 32'(o_Pmem_Addr), 32'h01);

        // Jump coincident with the ack of address 05.
        do_reset();
        for (int k = 0; k < 40 && !(m_req_open && m_req_addr == 8'h05); k++)
            step(1'b1, 1'b0, 1'b0, 8'h00, "to05");
        chk("reach_a5", 32'(o_Pmem_Addr), 32'h05);
        step(1'b1, 1'b0, 1'b1, 8'h40, "jmp_ack");
        chk("jmp_ack.valid", 32'(o_Instr_Valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 8'h00, "jmp_fetch");
        chk("jmp.iaddr", 32'(o_Instr_Addr), 32'h40);
        chk("jmp.instr", 32'(o_Instruction), 32'h50);

        // Jump while holding a stalled instruction, to FF, then wrap.
        step(1'b0, 1'b1, 1'b1, 8'hFF, "jmpff");
        step(1'b1, 1'b0, 1'b0, 8'h00, "ff_fetch");
        chk("ff.iaddr", 32'(o_Instr_Addr), 32'hFF);
        chk("ff.instr", 32'(o_Instruction), 32'h0F);
        step(1'b0, 1'b0, 1'b0, 8'h00, "ff_consume");
        chk("wrap.addr", 32'(o_Pmem_Addr), 32'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, "wrap_fetch");
        chk("wrap.iaddr", 32'(o_Instr_Addr), 32'h00);

        // Asynchronous reset mid-fetch while a late ack shows up.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, "mid0");
        step(1'b0, 1'b0, 1'b0, 8'h00, "mid1");
        ack  = 1'b1;
        data = 8'hA5;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        repeat (2) @(negedge clk);
        check_all("rst_ack_ignored");
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00, "restart0");
        chk("restart.addr", 32'(o_Pmem_Addr), 32'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00, "restart1");
        chk("restart.instr", 32'(o_Instruction), 32'h10);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 19) == 0), 8'($urandom), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
